outen4bit_buf: RTL and testbench
================================

OUTEN4BIT_BUF -- requirements
Module: outen4bit_buf

Interface
REQ-001 Parameter: WIDTH, 4, data word width in bits.
REQ-002 Parameter: DEPTH, 4, number of stored words; power of two only.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: clr  input  1  asynchronous, active-high reset.
REQ-005 Port: data_in  input  WIDTH  write word from the loading side.
REQ-006 Port: Inen  input  1  input enable; requests a write of data_in this cycle.
REQ-007 Port: Outen  input  1  output enable; requests a read of the oldest word this cycle.
REQ-008 Port: data_out  output  WIDTH  registered read word.
REQ-009 Port: out_valid  output  1  high for exactly one cycle when data_out carries a new word.
REQ-010 Port: full  output  1  buffer holds DEPTH words.
REQ-011 Port: empty  output  1  buffer holds zero words.
REQ-012 Port: count  output  log2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-013 Port: ovf  output  1  sticky flag; a write was refused.
REQ-014 Port: udf  output  1  sticky flag; a read was refused.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH register array with write and read pointers of log2(DEPTH) bits each.
REQ-016 Both pointers SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-017 A write SHALL be accepted on a clk edge when Inen=1 and the buffer is not full. It stores data_in at the write pointer and advances that pointer.
REQ-018 A read SHALL be accepted on a clk edge when Outen=1 and the buffer is not empty. The word at the read pointer is registered into data_out, the read pointer advances, and out_valid=1 for the following cycle.
REQ-019 Read latency SHALL be 1 cycle, from the edge sampling Outen=1 to data_out/out_valid being valid.
REQ-020 When no read is accepted, out_valid SHALL be 0 and data_out SHALL hold its previous value.
REQ-021 When Inen=1 and the buffer is full with no accepted read, the write SHALL be dropped, memory and count SHALL be unchanged, and ovf SHALL be set.
REQ-022 When Outen=1 and the buffer is empty, the read SHALL be refused, out_valid SHALL be 0, and udf SHALL be set.
REQ-023 Simultaneous Inen=1 and Outen=1 with 0<count<DEPTH SHALL perform both operations, leaving count unchanged.
REQ-024 Simultaneous Inen=1 and Outen=1 when full SHALL perform both operations, the read freeing the slot for the write. count stays DEPTH and ovf is not set.
REQ-025 Simultaneous Inen=1 and Outen=1 when empty SHALL accept only the write and set udf. count becomes 1 and out_valid=0.
REQ-026 count SHALL be maintained as: +1 for a write only, -1 for a read only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
REQ-027 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both derived from registered count.
REQ-028 The state view SHALL be EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH). Transitions occur only as given by REQ-026.
REQ-029 ovf and udf SHALL remain set until clr; no other clear path exists.
REQ-030 X on Inen or Outen is out of scope; the bench drives only 0/1.

Reset
REQ-031 clr=1 SHALL immediately, without waiting for clk, force:
- data_out=0, out_valid=0
- count=0, empty=1, full=0
- ovf=0, udf=0
- both pointers=0
REQ-032 Memory array contents need not be cleared; they SHALL be unobservable until rewritten.
REQ-033 clr asserted mid-operation SHALL abandon any in-flight read or write. The first accepted write after clr is released SHALL land at pointer 0.
REQ-034 While clr=1, Inen and Outen SHALL have no effect.

Verification
REQ-035 Reset then idle: clr=1 for 1 cycle, then Inen=Outen=0 for 4 cycles -> count=0, empty=1, full=0, data_out=0, out_valid=0, ovf=udf=0 throughout.
REQ-036 Fill and drain: write 0011, 1010, 1111, 1001 -> full=1, count=4. Then Outen=1 for 4 cycles -> data_out=0011, 1010, 1111, 1001 on consecutive cycles, each with out_valid=1, then empty=1.
REQ-037 Overflow: write 5 words (last word 0110) with no reads -> ovf=1, count=4. Draining returns the first 4 words only; 0110 never appears.
REQ-038 Underflow and empty corner: on empty, Outen=1 -> out_valid=0, udf=1, data_out unchanged. On empty, Inen=Outen=1 with data_in=1100 -> count=1, out_valid=0. Next Outen -> data_out=1100.
REQ-039 Full corner with wrap: fill to 4, then Inen=Outen=1 for 6 cycles with data_in 0001..0110 -> count stays 4, ovf=0. Reads return the original 4 words then 0001, 0010. The remaining drain returns 0011..0110, exercising pointer wrap.
REQ-040 Async reset mid-fill: after 2 writes, assert clr between clock edges -> outputs reach reset values before the next edge. Then a write of 0111 and a read return data_out=0111.

Source files
------------

// File: rtl/outen4bit_buf.sv
// -----------------------------------------------------------------------------
// outen4bit_buf
//   Small synchronous FIFO buffer. Words are loaded with Inen and unloaded with
//   Outen. Each accepted read places the oldest word on a registered data_out
//   one cycle later, together with a single-cycle out_valid pulse.
//   A write that finds the buffer full is dropped and sets the sticky ovf flag.
//   A read that finds the buffer empty is refused and sets the sticky udf flag.
//   Both flags are cleared only by clr.
//
// Ports
//   clk        in   1              rising-edge clock
//   clr        in   1              asynchronous active-high reset
//   data_in    in   WIDTH          word to write
//   Inen       in   1              write request
//   Outen      in   1              read request
//   data_out   out  WIDTH          registered read word
//   out_valid  out  1              data_out carries a new word this cycle
//   full       out  1              count == DEPTH
//   empty      out  1              count == 0
//   count      out  log2(DEPTH)+1  number of stored words
//   ovf        out  1              sticky: a write was refused
//   udf        out  1              sticky: a read was refused
//
// DEPTH must be a power of two, and at least 2, so that the pointers wrap
// naturally at their bit width.
// -----------------------------------------------------------------------------
module outen4bit_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     Inen,
  input  logic                     Outen,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout_p0;
  logic             r_vld_p0;
  logic             r_ovf;
  logic             r_udf;

  occ_t             w_occ;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_wr_refused;
  logic             w_rd_refused;
  logic [CW-1:0]    w_count_nxt;

  // Occupancy view derived purely from the registered count.
  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0) begin
      w_occ = OCC_EMPTY;
    end else if (r_count == CW'(DEPTH)) begin
      w_occ = OCC_FULL;
    end
  end

  // Request arbitration. A read is judged first because, when full, the read
  // frees the slot that a same-cycle write then reuses. When empty, the read
  // is refused but the write still lands.
  always_comb begin
    w_rd_acc     = Outen && (w_occ != OCC_EMPTY);
    w_wr_acc     = Inen && ((w_occ != OCC_FULL) || w_rd_acc);
    w_wr_refused = Inen && !w_wr_acc;
    w_rd_refused = Outen && !w_rd_acc;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage array: not reset; a slot is only ever read after being written.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !clr) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  // Pointers, count and sticky flags.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
      if (w_wr_refused) begin
        r_ovf <= 1'b1;
      end
      if (w_rd_refused) begin
        r_udf <= 1'b1;
      end
    end
  end

  // ---- stage p0: registered read word and its valid pulse ----
  // The read samples the array before any same-edge write, so a full-buffer
  // read/write pair returns the old word at the shared slot.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_dout_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout_p0 <= r_mem[r_rptr];
      end
    end
  end

  assign data_out  = r_dout_p0;
  assign out_valid = r_vld_p0;
  assign count     = r_count;
  assign full      = (w_occ == OCC_FULL);
  assign empty     = (w_occ == OCC_EMPTY);
  assign ovf       = r_ovf;
  assign udf       = r_udf;

endmodule

// File: tb/tb_outen4bit_buf.sv
// -----------------------------------------------------------------------------
// tb_outen4bit_buf
//   Directed scenarios followed by a randomized phase. Expected outputs come
//   from a queue-based model of the buffer's occupancy and ordering rules.
// -----------------------------------------------------------------------------
module tb_outen4bit_buf;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic [WIDTH-1:0] data_in;
  logic             Inen;
  logic             Outen;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [$clog2(DEPTH):0] count;
  logic             ovf;
  logic             udf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_vld;
  logic             m_ovf;
  logic             m_udf;

  outen4bit_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .data_in   (data_in),
    .Inen      (Inen),
    .Outen     (Outen),
    .data_out  (data_out),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},  32'(data_out),  32'(m_dout));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
    chk({tag, ".udf"},       32'(udf),       32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Rules: a read succeeds when something is stored; a write succeeds when
  // there is room, counting the slot freed by a same-cycle read.
  task automatic model_edge(input logic wi, input logic ro, input logic [WIDTH-1:0] d);
    bit rd;
    bit wr;
    rd = ro && (q.size() > 0);
    wr = wi && ((q.size() < DEPTH) || rd);
    if (rd) begin
      m_dout = q.pop_front();
      m_vld  = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    if (wr) q.push_back(d);
    if (wi && !wr) m_ovf = 1'b1;
    if (ro && !rd) m_udf = 1'b1;
  endtask

  // Called at a falling edge: drive, let the rising edge happen, check at the
  // next falling edge.
  task automatic cycle(input logic wi, input logic ro, input logic [WIDTH-1:0] d, input string tag);
    Inen    = wi;
    Outen   = ro;
    data_in = d;
    @(posedge clk);
    model_edge(wi, ro, d);
    @(negedge clk);
    check_all(tag);
  endtask

  // Synchronous-looking reset of one full cycle, with requests active to show
  // they are ignored while clr is high.
  task automatic do_reset(input string tag);
    clr     = 1'b1;
    Inen    = 1'b1;
    Outen   = 1'b1;
    data_in = 4'hA;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_all({tag, ".hold"});
    clr   = 1'b0;
    Inen  = 1'b0;
    Outen = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] pat [4];
    int n;
    clr = 1'b1; Inen = 1'b0; Outen = 1'b0; data_in = '0;
    model_reset();
    @(negedge clk);
    check_all("reset");

    // Reset then idle
    do_reset("r035");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'h0, "idle");

    // Fill and drain
    pat[0] = 4'b0011; pat[1] = 4'b1010; pat[2] = 4'b1111; pat[3] = 4'b1001;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, pat[i], "fill");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'h0, "drain");
    cycle(1'b0, 1'b0, 4'h0, "drained");

    // Overflow
    do_reset("r037");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'(i + 1), "ovfill");
    cycle(1'b1, 1'b0, 4'b0110, "ovf_write");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'h0, "ovdrain");

    // Underflow and empty corner
    do_reset("r038");
    cycle(1'b1, 1'b0, 4'b0101, "u_prime");
    cycle(1'b0, 1'b1, 4'h0, "u_read");
    cycle(1'b0, 1'b1, 4'h0, "udf_read");
    cycle(1'b1, 1'b1, 4'b1100, "empty_both");
    cycle(1'b0, 1'b1, 4'h0, "empty_both_rd");

    // Full corner with wrap
    do_reset("r039");
    pat[0] = 4'b1010; pat[1] = 4'b1011; pat[2] = 4'b1100; pat[3] = 4'b1101;
    cycle(1'b1, 1'b0, 4'h8, "wrap_pre");
    cycle(1'b0, 1'b1, 4'h0, "wrap_pre_rd");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, pat[i], "wfill");
    for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b1, 4'(i), "full_both");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'h0, "wdrain");
    cycle(1'b0, 1'b0, 4'h0, "wdone");

    // Asynchronous reset mid-fill
    do_reset("r040");
    cycle(1'b1, 1'b0, 4'h3, "af1");
    cycle(1'b1, 1'b1, 4'h4, "af2");
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_all("async_clr");
    @(posedge clk);
    @(negedge clk);
    check_all("async_hold");
    clr = 1'b0;
    cycle(1'b1, 1'b0, 4'b0111, "post_wr");
    cycle(1'b0, 1'b1, 4'h0, "post_rd");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      n = int'($urandom_range(0, 99));
      if (n == 0) begin
        do_reset("rnd_clr");
      end else begin
        cycle(1'($urandom), 1'($urandom), 4'($urandom), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
